// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle MIPS HI/LO multiply/divide unit with pipeline stall
// Optional MDU_FAST_MULT_EN: single-cycle mult/multu latency.
module mdu_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic        rd_hi,
    input  logic        flush,
    input  logic        d_mdu_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

`ifdef MDU_FAST_MULT_EN
    localparam logic [3:0] MUL_CNT = 4'd0;
`else
    localparam logic [3:0] MUL_CNT = 4'd4;
`endif
    localparam logic [3:0] DIV_CNT = 4'd9;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_signed;
    logic [63:0] w_prod;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_issue;

    assign w_is_signed = ~r_op[0];
    assign w_issue     = start & ~flush;

    // Signed divide works on magnitudes; 0x80000000 maps to itself, which gives the MIPS overflow result.
    always_comb begin
        w_prod  = 64'd0;
        w_abs_a = r_a;
        w_abs_b = r_b;
        w_q_mag = 32'd0;
        w_r_mag = 32'd0;
        w_quot  = 32'd0;
        w_rem   = 32'd0;
        if (w_is_signed) begin
            w_prod = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
        end else begin
            w_prod = {32'd0, r_a} * {32'd0, r_b};
        end
        if (w_is_signed && r_a[31]) w_abs_a = -r_a;
        if (w_is_signed && r_b[31]) w_abs_b = -r_b;
        if (r_b != 32'd0) begin
            w_q_mag = w_abs_a / w_abs_b;
            w_r_mag = w_abs_a % w_abs_b;
        end
        w_quot = (w_is_signed && (r_a[31] ^ r_b[31])) ? -w_q_mag : w_q_mag;
        w_rem  = (w_is_signed && r_a[31]) ? -w_r_mag : w_r_mag;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!flush) begin
                        if (hi_we) r_hi <= a;
                        if (lo_we) r_lo <= a;
                    end
                    if (w_issue) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_cnt   <= op[1] ? DIV_CNT : MUL_CNT;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= IDLE;
                        if (!r_op[1]) begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end else if (r_b != 32'd0) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = (r_state == BUSY);
    assign stall = d_mdu_use & (busy | w_issue);
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign rdata = rd_hi ? r_hi : r_lo;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low: ports clk (input, 1) and reset_n (input, 1).
REQ-002 The block SHALL have these ports:
  clk       input   1   rising-edge clock
  reset_n   input   1   synchronous active-low reset
  start     input   1   E-stage mult/multu/div/divu issue strobe
  op        input   2   00 mult, 01 multu, 10 div, 11 divu
  a         input   32  GPR[rs] operand
  b         input   32  GPR[rt] operand
  hi_we     input   1   mthi in E stage
  lo_we     input   1   mtlo in E stage
  rd_hi     input   1   1: rdata=HI (mfhi), 0: rdata=LO (mflo)
  flush     input   1   E-stage instruction cancelled by exception this cycle
  d_mdu_use input   1   D-stage instruction is an MDU instruction (start/mt*/mf*)
  busy      output  1   operation in progress
  stall     output  1   hold F/D, bubble E
  hi        output  32  HI register
  lo        output  32  LO register
  rdata     output  32  selected HI/LO for mfhi/mflo

Function
REQ-003 The block SHALL implement states IDLE and BUSY with a 4-bit down-counter cnt.
REQ-004 In IDLE, start=1 and flush=0 at edge N SHALL latch op, a and b, load cnt=L-1, and enter BUSY; L=5 for mult/multu, L=10 for div/divu.
REQ-005 In BUSY, cnt SHALL decrement each edge; at the edge where cnt=0 the block SHALL write HI/LO and return to IDLE, so the results are visible from edge N+L.
REQ-006 busy SHALL be 1 exactly while in BUSY (cycles N+1 .. N+L).
REQ-007 mult SHALL compute the signed 64-bit product and multu the unsigned 64-bit product; {HI,LO} SHALL receive product[63:32], product[31:0].
REQ-008 div SHALL compute the signed quotient to LO and remainder to HI, truncating toward zero with the remainder taking the dividend's sign; divu SHALL compute the unsigned quotient and remainder.
REQ-009 Division by zero (latched b=0) SHALL run the full L cycles and leave HI and LO unchanged.
REQ-010 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-011 In IDLE, hi_we=1 and flush=0 SHALL write a to HI at that edge, and lo_we SHALL likewise write a to LO; both writes are effective immediately and the state stays IDLE.
REQ-012 flush=1 SHALL suppress start, hi_we and lo_we in the same cycle; an operation already in BUSY SHALL complete and is not cancelled by flush.
REQ-013 In BUSY, start, hi_we and lo_we SHALL be ignored (protocol violation); they SHALL NOT affect cnt, the latched operands or HI/LO.
REQ-014 stall SHALL equal d_mdu_use & (busy | (start & ~flush)), combinationally.
REQ-015 rdata SHALL be combinational: rd_hi ? hi : lo, reflecting the registered HI/LO values.
REQ-016 The latched operands SHALL be used for the computation, so changes on a and b during BUSY have no effect.

Reset
REQ-017 When reset_n=0 at a rising edge, the block SHALL go to IDLE and set cnt=0, busy=0, hi=0, lo=0 and the latched operands to 0.
REQ-018 Reset asserted during BUSY SHALL abort the operation with no HI/LO write; reset SHALL take priority over start, hi_we and lo_we in the same cycle.

Configuration
REQ-019 With macro MDU_FAST_MULT_EN defined, mult/multu SHALL use L=1 (busy high for one cycle, result at edge N+1); div/divu SHALL remain at L=10.
REQ-020 Without MDU_FAST_MULT_EN, mult/multu SHALL use L=5; all other behaviour SHALL be identical with and without the macro.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - mult a=0xFFFFFFFE, b=3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
  - div a=-7 (0xFFFFFFF9), b=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; d_mdu_use=1 throughout -> stall=1 from the start cycle through the last busy cycle.
  - divu with b=0 after mthi 0x1234 and mtlo 0x5678 -> after 10 cycles, HI=0x1234 and LO=0x5678.
  - start with flush=1 -> busy stays 0 and HI/LO unchanged; mthi issued in BUSY -> ignored.
  - reset_n=0 at cycle 3 of a div -> next cycle busy=0, hi=lo=0; with MDU_FAST_MULT_EN defined, mult 2*3 -> LO=6 one cycle after start.
